// File: rtl/edge_event_arbiter_pkg.sv
// edge_event_pkg: shared event type, direction codes and output-stage states for edge_event_arbiter.
package edge_event_pkg;
  localparam int EVT_CH_W = 4;
  localparam int EVT_TS_W = 32;
  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;
  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                dir;
    logic [EVT_TS_W-1:0] ts;
  } evt_t;
  typedef enum logic {ST_IDLE, ST_HOLD} out_st_t;
endpackage

// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if: monitored lines, enables, event valid/ready stream and overflow flags.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4,
  parameter int TS_W = 16
);
  localparam int CH_W = $clog2(N_CH);
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] ch_en;
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_dir;
  logic [TS_W-1:0] evt_ts;
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] ovf_clr;
  modport master (
    output a, ch_en, evt_ready, ovf_clr,
    input  evt_valid, evt_ch, evt_dir, evt_ts, ovf
  );
  modport slave (
    input  a, ch_en, evt_ready, ovf_clr,
    output evt_valid, evt_ch, evt_dir, evt_ts, ovf
  );
endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among req, searching upward from ptr with wrap.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any_req
);
  always_comb begin
    any_req = |req;
    gnt_idx = '0;
    // scan farthest offset first so the closest requester to ptr overwrites last
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt_idx = W'((int'(ptr) + k) % N);
    gnt_onehot = any_req ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detect into timestamped pending slots, round-robin onto one valid/ready stream.
// Define EDGE_EVENT_ARBITER_SYNC2_EN to insert a 2-flop synchronizer on each input line.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TS_W = 16
) (
  input logic clk,
  input logic rst_n,
  edge_event_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);
  logic [N_CH-1:0] w_a, w_rise, w_fall, w_edge, w_gnt_oh, w_gnt, w_ovf_set;
  logic [CH_W-1:0] w_gnt_idx;
  logic            w_any, w_load;
  logic [N_CH-1:0] r_a_dly, r_pend_v, r_pend_dir, r_ovf;
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_pend_ts [N_CH];
  logic [CH_W-1:0] r_rr_ptr, r_evt_ch;
  logic            r_evt_valid, r_evt_dir;
  logic [TS_W-1:0] r_evt_ts;
  out_st_t         r_state;
`ifdef EDGE_EVENT_ARBITER_SYNC2_EN
  logic [N_CH-1:0] r_sync1, r_sync2;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) {r_sync2, r_sync1} <= '0;
    else {r_sync2, r_sync1} <= {r_sync1, bus.a};
  assign w_a = r_sync2;
`else
  assign w_a = bus.a;
`endif
  assign w_rise = ~r_a_dly & w_a;
  assign w_fall = r_a_dly & ~w_a;
  assign w_edge = (w_rise | w_fall) & bus.ch_en;
  rr_arbiter #(.N(N_CH)) u_rr (
    .req       (r_pend_v),
    .ptr       (r_rr_ptr),
    .gnt_onehot(w_gnt_oh),
    .gnt_idx   (w_gnt_idx),
    .any_req   (w_any)
  );
  assign w_load    = w_any & ((r_state == ST_IDLE) | bus.evt_ready);
  assign w_gnt     = w_load ? w_gnt_oh : '0;
  // a slot being granted this cycle frees up for a same-cycle edge, so that edge is not an overflow
  assign w_ovf_set = w_edge & r_pend_v & ~w_gnt;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_ts       <= '0;
      r_a_dly    <= '0;
      r_pend_v   <= '0;
      r_pend_dir <= '0;
      r_ovf      <= '0;
      for (int i = 0; i < N_CH; i++) r_pend_ts[i] <= '0;
    end else begin
      r_ts    <= r_ts + TS_W'(1);
      r_a_dly <= w_a;
      r_ovf   <= (r_ovf & ~bus.ovf_clr) | w_ovf_set;
      for (int i = 0; i < N_CH; i++)
        if (w_edge[i] & ~w_ovf_set[i]) begin
          r_pend_v[i]   <= 1'b1;
          r_pend_dir[i] <= w_rise[i] ? DIR_RISE : DIR_FALL;
          r_pend_ts[i]  <= r_ts;
        end else if (w_gnt[i]) r_pend_v[i] <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_dir   <= 1'b0;
      r_evt_ts    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_load ? ST_HOLD : (bus.evt_ready ? ST_IDLE : r_state);
      r_evt_valid <= w_load ? 1'b1 : (bus.evt_ready ? 1'b0 : r_evt_valid);
      if (w_load) begin
        r_evt_ch  <= w_gnt_idx;
        r_evt_dir <= r_pend_dir[w_gnt_idx];
        r_evt_ts  <= r_pend_ts[w_gnt_idx];
        r_rr_ptr  <= (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
      end
    end
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_ch    = r_evt_ch;
  assign bus.evt_dir   = r_evt_dir;
  assign bus.evt_ts    = r_evt_ts;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios for edge_event_arbiter (default build), plus a TS_W=4 instance for wrap.
module tb_edge_event_arbiter;
  import edge_event_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int tcount;
  evt_t got[$];
  int   got_t[$];
  evt_t got4[$];
  always #5 clk = ~clk;
  edge_event_arbiter_if #(.N_CH(4), .TS_W(16)) bus ();
  edge_event_arbiter_if #(.N_CH(4), .TS_W(4))  bus4 ();
  edge_event_arbiter #(.N_CH(4), .TS_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  edge_event_arbiter #(.N_CH(4), .TS_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  // reference free-running counter: value seen during the cycle after each posedge
  always @(posedge clk or posedge rst_n)
    if (rst_n) tcount <= 0;
    else tcount <= tcount + 1;
  always @(negedge clk)
    if (!rst_n) begin
      if (bus.evt_valid && bus.evt_ready) begin
        got.push_back('{ch: 4'(bus.evt_ch), dir: bus.evt_dir, ts: 32'(bus.evt_ts)});
        got_t.push_back(tcount);
      end
      if (bus4.evt_valid && bus4.evt_ready)
        got4.push_back('{ch: 4'(bus4.evt_ch), dir: bus4.evt_dir, ts: 32'(bus4.evt_ts)});
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle(input int n);
    repeat (n) step();
    got.delete();
    got_t.delete();
  endtask
  task automatic quiet_zero();
    bus.ch_en = 4'b0000;
    bus.a = 4'b0000;
    step();
    bus.ch_en = 4'b1111;
  endtask
  task automatic test_reset();
    rst_n = 1'b1;
    bus.a = 4'b0001;
    repeat (3) step();
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0h exp=0", bus.evt_valid); end
    n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL rst_ovf got=%0h exp=0", bus.ovf); end
    n_cmp++; if (bus.evt_ts !== 16'd0) begin n_err++; $display("FAIL rst_ts got=%0h exp=0", bus.evt_ts); end
    rst_n = 1'b0;
    got.delete();
    step();
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL start_early got=%0h exp=0", bus.evt_valid); end
    step();
    n_cmp++; if (bus.evt_valid !== 1'b1) begin n_err++; $display("FAIL start_valid got=%0h exp=1", bus.evt_valid); end
    n_cmp++; if ({bus.evt_ch, bus.evt_dir, bus.evt_ts} !== {2'd0, 1'b1, 16'd0}) begin n_err++; $display("FAIL start_evt got=ch%0d dir%0d ts%0d exp=ch0 dir1 ts0", bus.evt_ch, bus.evt_dir, bus.evt_ts); end
    repeat (5) step();
    n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL start_count got=%0d exp=1", got.size()); end
    bus.a = 4'b0000;
    settle(6);
  endtask
  task automatic test_latency();
    int t;
    for (int g = 0; g < 300 && tcount != 37; g++) step();
    n_cmp++; if (tcount != 37) begin n_err++; $display("FAIL lat_reach got=%0d exp=37", tcount); end
    bus.a[2] = 1'b1;
    step();
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1 got=%0h exp=0", bus.evt_valid); end
    step();
    n_cmp++; if ({bus.evt_valid, bus.evt_ch, bus.evt_dir, bus.evt_ts} !== {1'b1, 2'd2, 1'b1, 16'd37}) begin n_err++; $display("FAIL lat_rise got=v%0d ch%0d dir%0d ts%0d exp=v1 ch2 dir1 ts37", bus.evt_valid, bus.evt_ch, bus.evt_dir, bus.evt_ts); end
    repeat (3) step();
    bus.a[2] = 1'b0;
    t = tcount;
    step();
    step();
    n_cmp++; if ({bus.evt_valid, bus.evt_ch, bus.evt_dir, bus.evt_ts} !== {1'b1, 2'd2, 1'b0, 16'(t)}) begin n_err++; $display("FAIL lat_fall got=v%0d ch%0d dir%0d ts%0d exp=v1 ch2 dir0 ts%0d", bus.evt_valid, bus.evt_ch, bus.evt_dir, bus.evt_ts, t); end
    settle(4);
  endtask
  task automatic test_round_robin();
    int t;
    int ord_a[4] = '{0, 1, 2, 3};
    int ord_b[4] = '{2, 3, 0, 1};
    bus.a[3] = 1'b1;
    settle(5);
    quiet_zero();
    got.delete(); got_t.delete();
    bus.a = 4'b1111;
    t = tcount;
    repeat (8) step();
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL rr0_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if ({got[k].ch, got[k].dir, got[k].ts} !== {4'(ord_a[k]), 1'b1, 32'(t)}) begin n_err++; $display("FAIL rr0_evt%0d got=ch%0d dir%0d ts%0d exp=ch%0d dir1 ts%0d", k, got[k].ch, got[k].dir, got[k].ts, ord_a[k], t); end
      n_cmp++; if (got_t[k] !== got_t[0] + k) begin n_err++; $display("FAIL rr0_b2b%0d got=%0d exp=%0d", k, got_t[k], got_t[0] + k); end
    end
    quiet_zero();
    bus.a = 4'b0010;
    settle(5);
    quiet_zero();
    got.delete(); got_t.delete();
    bus.a = 4'b1111;
    t = tcount;
    repeat (8) step();
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL rr2_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if ({got[k].ch, got[k].dir, got[k].ts} !== {4'(ord_b[k]), 1'b1, 32'(t)}) begin n_err++; $display("FAIL rr2_evt%0d got=ch%0d dir%0d ts%0d exp=ch%0d dir1 ts%0d", k, got[k].ch, got[k].dir, got[k].ts, ord_b[k], t); end
    end
    settle(2);
  endtask
  task automatic test_overflow();
    int t0, t1;
    quiet_zero();
    got.delete(); got_t.delete();
    bus.evt_ready = 1'b0;
    bus.a[0] = 1'b1;
    t0 = tcount;
    step(); step();
    bus.a[1] = 1'b1;
    t1 = tcount;
    step();
    bus.a[1] = 1'b0;
    step();
    n_cmp++; if (bus.ovf !== 4'b0010) begin n_err++; $display("FAIL ovf_set got=%0h exp=2", bus.ovf); end
    n_cmp++; if ({bus.evt_valid, bus.evt_ch, bus.evt_ts} !== {1'b1, 2'd0, 16'(t0)}) begin n_err++; $display("FAIL ovf_hold got=v%0d ch%0d ts%0d exp=v1 ch0 ts%0d", bus.evt_valid, bus.evt_ch, bus.evt_ts, t0); end
    bus.evt_ready = 1'b1;
    repeat (6) step();
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL ovf_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if ({got[1].ch, got[1].dir, got[1].ts} !== {4'd1, 1'b1, 32'(t1)}) begin n_err++; $display("FAIL ovf_kept got=ch%0d dir%0d ts%0d exp=ch1 dir1 ts%0d", got[1].ch, got[1].dir, got[1].ts, t1); end
    end
    n_cmp++; if (bus.ovf !== 4'b0010) begin n_err++; $display("FAIL ovf_sticky got=%0h exp=2", bus.ovf); end
    bus.ovf_clr = 4'b0010;
    step();
    bus.ovf_clr = 4'b0000;
    n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL ovf_clr got=%0h exp=0", bus.ovf); end
    bus.evt_ready = 1'b0;
    bus.a[0] = 1'b0;
    step(); step();
    bus.a[1] = 1'b1;
    step();
    bus.a[1] = 1'b0;
    bus.ovf_clr = 4'b0010;
    step();
    bus.ovf_clr = 4'b0000;
    n_cmp++; if (bus.ovf !== 4'b0010) begin n_err++; $display("FAIL ovf_set_wins got=%0h exp=2", bus.ovf); end
    bus.ovf_clr = 4'b0010;
    bus.evt_ready = 1'b1;
    step();
    bus.ovf_clr = 4'b0000;
    settle(6);
  endtask
  task automatic test_collision();
    int t;
    got.delete(); got_t.delete();
    bus.a[3] = 1'b1;
    t = tcount;
    step();
    bus.a[3] = 1'b0;
    repeat (6) step();
    n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL col_ovf got=%0h exp=0", bus.ovf); end
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL col_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if ({got[0].ch, got[0].dir, got[0].ts} !== {4'd3, 1'b1, 32'(t)}) begin n_err++; $display("FAIL col_first got=ch%0d dir%0d ts%0d exp=ch3 dir1 ts%0d", got[0].ch, got[0].dir, got[0].ts, t); end
      n_cmp++; if ({got[1].ch, got[1].dir, got[1].ts} !== {4'd3, 1'b0, 32'(t + 1)}) begin n_err++; $display("FAIL col_reload got=ch%0d dir%0d ts%0d exp=ch3 dir0 ts%0d", got[1].ch, got[1].dir, got[1].ts, t + 1); end
    end
    settle(2);
  endtask
  task automatic test_mask();
    bus.ch_en = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      bus.a[0] = ~bus.a[0];
      step();
    end
    repeat (4) step();
    n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL mask_none got=%0d exp=0", got.size()); end
    bus.ch_en = 4'b1111;
    repeat (3) step();
    n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL mask_reen got=%0d exp=0", got.size()); end
    bus.evt_ready = 1'b0;
    bus.a[1] = 1'b1;
    step(); step();
    bus.a[0] = 1'b1;
    step();
    bus.ch_en = 4'b1110;
    bus.evt_ready = 1'b1;
    repeat (5) step();
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL mask_keep_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if ({got[1].ch, got[1].dir} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL mask_keep got=ch%0d dir%0d exp=ch0 dir1", got[1].ch, got[1].dir); end
    end
    bus.ch_en = 4'b1111;
    settle(2);
  endtask
  task automatic test_wrap();
    for (int g = 0; g < 40 && (tcount % 16) != 15; g++) step();
    bus4.a[2] = 1'b1;
    step();
    bus4.a[2] = 1'b0;
    repeat (6) step();
    n_cmp++; if (got4.size() !== 2) begin n_err++; $display("FAIL wrap_count got=%0d exp=2", got4.size()); end
    if (got4.size() == 2) begin
      n_cmp++; if ({got4[0].dir, got4[0].ts} !== {1'b1, 32'd15}) begin n_err++; $display("FAIL wrap_15 got=dir%0d ts%0d exp=dir1 ts15", got4[0].dir, got4[0].ts); end
      n_cmp++; if ({got4[1].dir, got4[1].ts} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL wrap_0 got=dir%0d ts%0d exp=dir0 ts0", got4[1].dir, got4[1].ts); end
    end
  endtask
  task automatic test_midreset();
    got.delete(); got_t.delete();
    bus.evt_ready = 1'b0;
    bus.a[2] = 1'b1;
    step(); step();
    bus.a[3] = 1'b1;
    step();
    n_cmp++; if (bus.evt_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got=%0h exp=1", bus.evt_valid); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({bus.evt_valid, bus.evt_ch, bus.evt_ts} !== {1'b1 ^ 1'b1, 2'd0, 16'd0}) begin n_err++; $display("FAIL mid_clear got=v%0d ch%0d ts%0d exp=v0 ch0 ts0", bus.evt_valid, bus.evt_ch, bus.evt_ts); end
    bus.a = 4'b0000;
    bus.evt_ready = 1'b1;
    step();
    rst_n = 1'b0;
    repeat (6) step();
    n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL mid_discard got=%0d exp=0", got.size()); end
  endtask
  initial begin
    bus.a = '0; bus.ch_en = '1; bus.evt_ready = 1'b1; bus.ovf_clr = '0;
    bus4.a = '0; bus4.ch_en = '1; bus4.evt_ready = 1'b1; bus4.ovf_clr = '0;
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_collision();
    test_mask();
    test_wrap();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event scheduler. Each input line gets a rise/fall detector with a one-flop delay compare.
- Detected edges are timestamped and held in a per-channel pending slot.
- A round-robin arbiter shares a single valid/ready event output among all channels.
- Sits between raw control/status lines and the event consumer (CPU-side FIFO or logger).

Parameters:
- N_CH, 4, number of input channels (2..16).
- TS_W, 16, timestamp counter width.
- CH_W, $clog2(N_CH), channel index width (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-high (block is in reset while rst_n==1).
- a  in  N_CH  monitored lines; a[i] is channel i.
- ch_en  in  N_CH  per-channel enable; 0 masks new edges on that channel.
- evt_valid  out  1  event output valid.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- evt_ch  out  CH_W  channel index of the presented event.
- evt_dir  out  1  1 = rising edge, 0 = falling edge.
- evt_ts  out  TS_W  timestamp of the edge.
- ovf  out  N_CH  sticky per-channel overflow (event dropped).
- ovf_clr  in  N_CH  per-bit clear of ovf.

Behaviour:
- Reset values: all registers 0; evt_valid, evt_ch, evt_dir, evt_ts, ovf = 0; delay flops a_dly = 0; ts counter = 0; round-robin pointer = 0.
- Reset mid-operation discards all pending and presented events immediately.
- Out of reset, a line already high produces a rise event on the first active cycle, because a_dly starts at 0.
- Timestamp: a free-running counter of TS_W bits, incremented every cycle. It wraps from 2^TS_W-1 to 0 with no flag.
- Edge detect, per channel i, evaluated in cycle C:
  - rise = ~a_dly[i] & a[i]; fall = a_dly[i] & ~a[i].
  - a_dly[i] <= a[i] every cycle, regardless of ch_en.
  - An edge counts only if ch_en[i]==1 in cycle C.
- Pending slot per channel (pend_v, pend_dir, pend_ts):
  - A qualified edge in cycle C sets pend_v=1, pend_dir, and pend_ts = counter value in C. These are visible in C+1.
  - If a new edge arrives while pend_v=1 and the slot is not being granted in the same cycle: the new edge is dropped, the old event is kept, and ovf[i] <= 1.
  - If a new edge arrives in the same cycle the slot is granted: the slot reloads with the new edge and there is no overflow.
  - Deasserting ch_en does not clear an existing pending slot.
- Output stage, 2 states:
  - IDLE (evt_valid=0): any pend_v -> load the winner into the output registers and go to HOLD in the next cycle.
  - HOLD (evt_valid=1): outputs are stable until evt_valid & evt_ready.
  - On accept: if any pend_v, load the next winner in the same cycle (back-to-back, one event per cycle at full throughput). Otherwise go to IDLE.
- Arbitration:
  - Round-robin among pend_v bits, searching from rr_ptr upward with wrap.
  - On each load, rr_ptr <= winner+1 mod N_CH.
  - Load clears the winner's pend_v (subject to the same-cycle reload rule above).
- Latency: edge detected in cycle C -> evt_valid high in C+2 when the output is idle and no contention.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr[i] clears bit i.

Optional Feature:
- Macro: EDGE_EVENT_ARBITER_SYNC2_EN.
- Defined: a 2-flop synchronizer (reset 0) is inserted on each a[i] ahead of the edge detector. Latency from the a change becomes 2 cycles longer; pend_ts reflects the synchronized detect cycle.
- Undefined: a feeds the detector directly; inputs must already be synchronous to clk.

Decomposition:
- Package edge_event_pkg:
  - typedef evt_t struct {ch, dir, ts}.
  - localparams DIR_RISE=1, DIR_FALL=0.
  - Output-state enum {ST_IDLE, ST_HOLD}.
- Sub-module rr_arbiter, parameter N: inputs req[N] and ptr; outputs gnt_onehot, gnt_idx and any_req. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset/startup: hold a=4'b0001 through reset release, evt_ready=1 -> one event ch=0, dir=1, ts=0 at cycle 2 after release; nothing else.
- Single edge latency: a[2] 0->1 detected in cycle C, ts counter=37 -> evt_valid in C+2 with ch=2, dir=1, ts=37; a[2] 1->0 later -> dir=0.
- Contention and round-robin: rise on all 4 channels in the same cycle, evt_ready=1 -> four consecutive events in order ch0, ch1, ch2, ch3 with identical ts; repeat with rr_ptr=2 -> order 2, 3, 0, 1.
- Backpressure and overflow: evt_ready=0, ch1 rises then falls while pending -> presented/pending rise kept, fall dropped, ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0; set and clr in the same cycle -> stays 1.
- Grant/reload collision: ch3 pending, granted in the same cycle as a new ch3 fall -> no ovf, next ch3 event has dir=0 with the new ts.
- Masking and wrap: ch_en[0]=0 while a[0] toggles -> no ch0 events. With TS_W=4, an edge at counter 15 and the next at counter 0 -> ts 15 then 0.
